// File: rtl/lector_memoria.sv
// Multi-cycle RV32I load sequencer: issues 1/2/4 byte reads to a byte-wide
// synchronous memory, assembles them little-endian and sign/zero extends.
module lector_memoria (
  input  logic        clk,
  input  logic        rst,
  input  logic        inicio,
  input  logic [31:0] dir,
  input  logic [2:0]  funct3,
  output logic [31:0] mem_dir,
  output logic        mem_lee,
  input  logic [7:0]  mem_dato,
  output logic        ocupado,
  output logic        listo,
  output logic        error,
  output logic [31:0] dato
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    LECTURA = 2'd1,
    FIN     = 2'd2
  } estado_t;

  estado_t         estado_q, estado_d;
  logic [AW-1:0]   dir_q, dir_d;
  logic [2:0]      f3_q, f3_d;
  logic [CW-1:0]   n_q, n_d;
  logic [CW-1:0]   k_q, k_d;
  logic [CW-1:0]   j_q, j_d;
  logic [DW-1:0]   buf_q, buf_d;
  logic            pend_q, pend_d;
  logic [AW-1:0]   mem_dir_d;
  logic            mem_lee_d;
  logic            ocupado_d;
  logic            listo_d;
  logic            error_d;
  logic [DW-1:0]   dato_d;

  logic            valida_c;
  logic [CW-1:0]   largo_c;

  // Final sign/zero extension of the assembled little-endian buffer.
  function automatic logic [DW-1:0] extender(input logic [DW-1:0] b, input logic [2:0] f);
    logic [DW-1:0] r;
    r = b;
    case (f[1:0])
      2'b00:   r = {{24{b[7]  & ~f[2]}}, b[7:0]};
      2'b01:   r = {{16{b[15] & ~f[2]}}, b[15:0]};
      default: r = b;
    endcase
    return r;
  endfunction

  // Request decode: legal funct3 plus natural alignment for halfword/word.
  always_comb begin
    valida_c = 1'b0;
    largo_c  = CW'(1);
    case (funct3)
      3'b000, 3'b100: begin
        valida_c = 1'b1;
        largo_c  = CW'(1);
      end
      3'b001, 3'b101: begin
        valida_c = ~dir[0];
        largo_c  = CW'(2);
      end
      3'b010: begin
        valida_c = (dir[1:0] == 2'b00);
        largo_c  = CW'(4);
      end
      default: begin
        valida_c = 1'b0;
        largo_c  = CW'(1);
      end
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    estado_d  = estado_q;
    dir_d     = dir_q;
    f3_d      = f3_q;
    n_d       = n_q;
    k_d       = k_q;
    j_d       = j_q;
    buf_d     = buf_q;
    pend_d    = mem_lee;
    mem_lee_d = 1'b0;
    mem_dir_d = mem_dir;
    ocupado_d = ocupado;
    listo_d   = 1'b0;
    error_d   = 1'b0;
    dato_d    = dato;

    case (estado_q)
      REPOSO, FIN: begin
        estado_d  = REPOSO;
        ocupado_d = 1'b0;
        if (inicio) begin
          dir_d = dir;
          f3_d  = funct3;
          k_d   = '0;
          j_d   = '0;
          buf_d = '0;
          if (!valida_c) begin
            estado_d = FIN;
            listo_d  = 1'b1;
            error_d  = 1'b1;
            dato_d   = '0;
          end else begin
            estado_d  = LECTURA;
            n_d       = largo_c;
            mem_lee_d = 1'b1;
            mem_dir_d = dir;
            k_d       = CW'(1);
            ocupado_d = 1'b1;
          end
        end
      end

      LECTURA: begin
        ocupado_d = 1'b1;
        if (k_q < n_q) begin
          mem_lee_d = 1'b1;
          mem_dir_d = dir_q + AW'(k_q);
          k_d       = k_q + CW'(1);
        end
        // Data returns one cycle after its strobe; lane j follows issue order.
        if (pend_q) begin
          case (j_q[1:0])
            2'd0:    buf_d[7:0]   = mem_dato;
            2'd1:    buf_d[15:8]  = mem_dato;
            2'd2:    buf_d[23:16] = mem_dato;
            default: buf_d[31:24] = mem_dato;
          endcase
          j_d = j_q + CW'(1);
          if (j_q == n_q - CW'(1)) begin
            estado_d  = FIN;
            ocupado_d = 1'b0;
            listo_d   = 1'b1;
            dato_d    = extender(buf_d, f3_q);
          end
        end
      end

      default: begin
        estado_d  = REPOSO;
        ocupado_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q <= REPOSO;
      dir_q    <= '0;
      f3_q     <= '0;
      n_q      <= '0;
      k_q      <= '0;
      j_q      <= '0;
      buf_q    <= '0;
      pend_q   <= 1'b0;
      mem_dir  <= '0;
      mem_lee  <= 1'b0;
      ocupado  <= 1'b0;
      listo    <= 1'b0;
      error    <= 1'b0;
      dato     <= '0;
    end else begin
      estado_q <= estado_d;
      dir_q    <= dir_d;
      f3_q     <= f3_d;
      n_q      <= n_d;
      k_q      <= k_d;
      j_q      <= j_d;
      buf_q    <= buf_d;
      pend_q   <= pend_d;
      mem_dir  <= mem_dir_d;
      mem_lee  <= mem_lee_d;
      ocupado  <= ocupado_d;
      listo    <= listo_d;
      error    <= error_d;
      dato     <= dato_d;
    end
  end

endmodule

// File: tb/tb_lector_memoria.sv
// Directed self-checking bench for lector_memoria with a 1-cycle byte memory model.
module tb_lector_memoria;

  logic        clk = 1'b0;
  logic        rst;
  logic        inicio;
  logic [31:0] dir;
  logic [2:0]  funct3;
  logic [31:0] mem_dir;
  logic        mem_lee;
  logic [7:0]  mem_dato;
  logic        ocupado;
  logic        listo;
  logic        error;
  logic [31:0] dato;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [0:4095];

  lector_memoria dut (
    .clk      (clk),
    .rst      (rst),
    .inicio   (inicio),
    .dir      (dir),
    .funct3   (funct3),
    .mem_dir  (mem_dir),
    .mem_lee  (mem_lee),
    .mem_dato (mem_dato),
    .ocupado  (ocupado),
    .listo    (listo),
    .error    (error),
    .dato     (dato)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_lee) mem_dato <= mem[mem_dir[11:0]];
  end

  // Results captured by run() for the test tasks to compare.
  int          lat;
  logic [31:0] dres;
  logic        eres;
  int          lee_n;
  logic [31:0] lee_dir [0:7];
  int          lee_cyc [0:7];
  logic        ocup_c1;
  logic        ocup_fin;

  task automatic go(input logic [31:0] a, input logic [2:0] f);
    @(negedge clk);
    inicio = 1'b1;
    dir    = a;
    funct3 = f;
  endtask

  // Observes cycles C1..Cmaxc; optionally drives inicio at cycle inj (or at listo when inj<0).
  task automatic run(input int maxc, input int inj, input logic [31:0] idir, input logic [2:0] if3);
    lat   = -1;
    lee_n = 0;
    dres  = 32'hDEADBEEF;
    eres  = 1'bx;
    ocup_c1  = 1'bx;
    ocup_fin = 1'bx;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (i == 1) ocup_c1 = ocupado;
      if (mem_lee && lee_n < 8) begin
        lee_dir[lee_n] = mem_dir;
        lee_cyc[lee_n] = i;
        lee_n++;
      end
      inicio = 1'b0;
      if (i == inj || (inj < 0 && listo)) begin
        inicio = 1'b1;
        dir    = idir;
        funct3 = if3;
      end
      if (listo) begin
        lat      = i;
        dres     = dato;
        eres     = error;
        ocup_fin = ocupado;
        break;
      end
    end
  endtask

  task automatic test_reset;
    inicio = 1'b0;
    dir    = '0;
    funct3 = '0;
    rst    = 1'b0;
    #12;
    checks++;
    if ({mem_dir, mem_lee, ocupado, listo, error, dato} !== 67'd0) begin
      errors++;
      $display("FAIL reset_state: got mem_dir=%h mem_lee=%b ocupado=%b listo=%b error=%b dato=%h, want all 0",
               mem_dir, mem_lee, ocupado, listo, error, dato);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lw;
    go(32'h100, 3'b010);
    run(12, 0, '0, '0);
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL lw_latency: got C%0d want C6", lat); end
    checks++;
    if (dres !== 32'h12345678 || eres !== 1'b0) begin
      errors++; $display("FAIL lw_data: got dato=%h error=%b want 12345678/0", dres, eres);
    end
    checks++;
    if (lee_n !== 4) begin errors++; $display("FAIL lw_strobes: got %0d want 4", lee_n); end
    for (int k = 0; k < 4 && k < lee_n; k++) begin
      checks++;
      if (lee_dir[k] !== 32'h100 + 32'(k) || lee_cyc[k] !== k + 1) begin
        errors++;
        $display("FAIL lw_addr%0d: got %h in C%0d want %h in C%0d", k, lee_dir[k], lee_cyc[k], 32'h100 + 32'(k), k + 1);
      end
    end
    checks++;
    if (ocup_c1 !== 1'b1 || ocup_fin !== 1'b0) begin
      errors++; $display("FAIL lw_ocupado: got C1=%b FIN=%b want 1/0", ocup_c1, ocup_fin);
    end
  endtask

  task automatic test_lb;
    go(32'h201, 3'b000);
    run(8, 0, '0, '0);
    checks++;
    if (lat !== 3 || dres !== 32'hFFFFFF80 || eres !== 1'b0) begin
      errors++; $display("FAIL lb: got C%0d dato=%h err=%b want C3 FFFFFF80 0", lat, dres, eres);
    end
    checks++;
    if (lee_n !== 1 || lee_dir[0] !== 32'h201) begin
      errors++; $display("FAIL lb_strobe: got n=%0d addr=%h want 1 201", lee_n, lee_dir[0]);
    end
    go(32'h201, 3'b100);
    run(8, 0, '0, '0);
    checks++;
    if (lat !== 3 || dres !== 32'h00000080) begin
      errors++; $display("FAIL lbu: got C%0d dato=%h want C3 00000080", lat, dres);
    end
  endtask

  task automatic test_lh;
    go(32'h302, 3'b001);
    run(8, 0, '0, '0);
    checks++;
    if (lat !== 4 || dres !== 32'hFFFFFFFE || eres !== 1'b0) begin
      errors++; $display("FAIL lh: got C%0d dato=%h err=%b want C4 FFFFFFFE 0", lat, dres, eres);
    end
    checks++;
    if (lee_n !== 2 || lee_dir[0] !== 32'h302 || lee_dir[1] !== 32'h303) begin
      errors++; $display("FAIL lh_strobes: got n=%0d %h %h want 2 302 303", lee_n, lee_dir[0], lee_dir[1]);
    end
    go(32'h302, 3'b101);
    run(8, 0, '0, '0);
    checks++;
    if (lat !== 4 || dres !== 32'h0000FFFE) begin
      errors++; $display("FAIL lhu: got C%0d dato=%h want C4 0000FFFE", lat, dres);
    end
  endtask

  task automatic test_errors;
    logic [31:0] a [0:2];
    logic [2:0]  f [0:2];
    a[0] = 32'h101; f[0] = 3'b010;
    a[1] = 32'h303; f[1] = 3'b001;
    a[2] = 32'h200; f[2] = 3'b011;
    for (int t = 0; t < 3; t++) begin
      go(a[t], f[t]);
      run(4, 0, '0, '0);
      checks++;
      if (lat !== 1 || eres !== 1'b1 || dres !== 32'h0) begin
        errors++; $display("FAIL err%0d: got C%0d error=%b dato=%h want C1 1 0", t, lat, eres, dres);
      end
      checks++;
      if (lee_n !== 0 || ocup_c1 !== 1'b0) begin
        errors++; $display("FAIL err%0d_quiet: got strobes=%0d ocupado=%b want 0 0", t, lee_n, ocup_c1);
      end
    end
  endtask

  task automatic test_ignore;
    go(32'h100, 3'b010);
    run(12, 2, 32'h201, 3'b000);
    checks++;
    if (lat !== 6 || dres !== 32'h12345678 || lee_n !== 4) begin
      errors++; $display("FAIL ignore: got C%0d dato=%h strobes=%0d want C6 12345678 4", lat, dres, lee_n);
    end
    run(6, 0, '0, '0);
    checks++;
    if (lat !== -1 || lee_n !== 0) begin
      errors++; $display("FAIL ignore_dropped: got listo C%0d strobes=%0d want none", lat, lee_n);
    end
  endtask

  task automatic test_back_to_back;
    go(32'h100, 3'b010);
    run(12, -1, 32'h10, 3'b000);
    checks++;
    if (lat !== 6 || dres !== 32'h12345678) begin
      errors++; $display("FAIL b2b_first: got C%0d dato=%h want C6 12345678", lat, dres);
    end
    run(8, 0, '0, '0);
    checks++;
    if (lee_n !== 1 || lee_cyc[0] !== 1 || lee_dir[0] !== 32'h10) begin
      errors++; $display("FAIL b2b_strobe: got n=%0d C%0d addr=%h want 1 C1 10", lee_n, lee_cyc[0], lee_dir[0]);
    end
    checks++;
    if (lat !== 3 || dres !== 32'h0000007F) begin
      errors++; $display("FAIL b2b_second: got C%0d dato=%h want C3 0000007F", lat, dres);
    end
  endtask

  task automatic test_reset_mid;
    int nlisto;
    go(32'h100, 3'b010);
    run(2, 0, '0, '0);
    checks++;
    if (ocupado !== 1'b1 || dato !== 32'h0000007F) begin
      errors++; $display("FAIL mid_pre: got ocupado=%b dato=%h want 1 0000007F", ocupado, dato);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mem_dir, mem_lee, ocupado, listo, error, dato} !== 67'd0) begin
      errors++;
      $display("FAIL mid_reset: got mem_dir=%h mem_lee=%b ocupado=%b listo=%b error=%b dato=%h, want all 0",
               mem_dir, mem_lee, ocupado, listo, error, dato);
    end
    @(negedge clk);
    rst = 1'b1;
    nlisto = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (listo || mem_lee) nlisto++;
    end
    checks++;
    if (nlisto !== 0) begin errors++; $display("FAIL mid_no_listo: got %0d active cycles want 0", nlisto); end
    go(32'h201, 3'b000);
    run(8, 0, '0, '0);
    checks++;
    if (lat !== 3 || dres !== 32'hFFFFFF80) begin
      errors++; $display("FAIL mid_clean: got C%0d dato=%h want C3 FFFFFF80", lat, dres);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'h78; mem[12'h101] = 8'h56;
    mem[12'h102] = 8'h34; mem[12'h103] = 8'h12;
    mem[12'h201] = 8'h80;
    mem[12'h302] = 8'hFE; mem[12'h303] = 8'hFF;
    mem[12'h010] = 8'h7F;
    mem_dato = 8'h00;

    test_reset;
    test_lw;
    test_lb;
    test_lh;
    test_errors;
    test_ignore;
    test_back_to_back;
    test_reset_mid;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lector_memoria.md
# lector_memoria

Multi-cycle load sequencer for the RV32I core: reads 1, 2 or 4 bytes from a byte-wide synchronous data memory, assembles them little-endian and applies RV32I load sign/zero extension (LB, LH, LW, LBU, LHU). It sits between the execute stage and data memory, on the read side of the path whose results end up in the 32-bit pipeline/destination registers. The execute stage uses a start/busy/done handshake; the memory uses a one-cycle-latency read strobe.

## Interface
- Parameters: none. Address and data widths are fixed at 32 bits; the memory read latency is fixed at 1 cycle.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- inicio  in  1  start request, sampled on a rising edge when ocupado=0.
- dir  in  32  byte address of the load, sampled with inicio.
- funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. All other codes are invalid.
- mem_dir  out  32  byte address to memory (registered).
- mem_lee  out  1  memory read strobe (registered).
- mem_dato  in  8  memory read data, valid the cycle after the matching mem_lee cycle.
- ocupado  out  1  a load is in progress; inicio is ignored while this is high.
- listo  out  1  one-cycle completion pulse.
- error  out  1  high together with listo when the request was misaligned or invalid.
- dato  out  32  extended load result; held until the next completion.

## Operation
- States: REPOSO, LECTURA, FIN.
- REPOSO or FIN, with inicio=1 at an edge: latch dir and funct3, then check the request.
  - Invalid funct3, LH/LHU with dir[0]=1, or LW with dir[1:0]≠00 → go to FIN with error=1 and dato=0. No memory access is made.
  - Otherwise → go to LECTURA with N=1 (LB/LBU), 2 (LH/LHU) or 4 (LW).
- LECTURA uses two counters:
  - Issue counter k=0..N-1 drives mem_lee=1 and mem_dir=dir+k.
  - Receive counter j captures mem_dato into byte lane j of an internal buffer.
- After the last byte is captured, compute dato and go to FIN.
  - LB: bits [31:8] = buffer bit 7. LBU: bits [31:8] = 0.
  - LH: bits [31:16] = buffer bit 15. LHU: bits [31:16] = 0.
  - LW: buffer passes through unchanged.
- FIN lasts one cycle: listo=1, error valid. Next state is REPOSO, or LECTURA/FIN if a new inicio is accepted in that same cycle (back-to-back).
- Address arithmetic is mod 2^32. Aligned requests never cross a word, so no wrap occurs in practice.
- inicio while ocupado=1 is dropped. It is not queued.

## Timing
- Edge E0 samples inicio. Ci denotes the cycle following edge Ei-1.
- Valid request:
  - mem_lee=1 in C1..CN, with mem_dir = dir+0 .. dir+N-1.
  - Byte k is captured at the end of C(k+2).
  - listo=1 in C(N+2): C3 for LB/LBU, C4 for LH/LHU, C6 for LW.
- Error request: listo=error=1 in C1. mem_lee stays 0.
- ocupado=1 from C1 through C(N+1) and 0 in the FIN cycle. For an error request, ocupado stays 0.
- dato changes only on the edge entering FIN.
- mem_dir holds its last value when mem_lee=0.
- Reset values: state REPOSO, mem_lee=0, mem_dir=0, ocupado=0, listo=0, error=0, dato=0, counters 0.
- rst low mid-operation: all outputs go to reset values immediately. The aborted load never produces listo. After rst is released, the next accepted inicio starts a clean load.

## Test plan
- Reset: drive rst=0 mid-LW.
  - Required: all outputs 0 immediately, with no clock edge needed.
  - After release, with no inicio, listo never asserts.
- LW at 0x00000100, memory bytes 0x100..0x103 = 78,56,34,12.
  - Required: mem_lee high in C1..C4 with mem_dir 0x100..0x103.
  - Required: listo in C6, dato=0x12345678, error=0.
- LB at 0x00000201, byte = 0x80.
  - Required: dato=0xFFFFFF80 with listo in C3.
  - LBU at the same address: dato=0x00000080.
- LH at 0x00000302, bytes FE,FF.
  - Required: dato=0xFFFFFFFE with listo in C4.
  - LHU at the same address: dato=0x0000FFFE.
- Error cases: LW at 0x00000101, LH at 0x00000303, and funct3=011.
  - Required: listo=error=1 in C1, dato=0, mem_lee never asserted.
- Handshake:
  - inicio pulsed while ocupado=1 → ignored, and the first result is unchanged.
  - inicio with LB 0x10 in the FIN cycle of a prior LW → accepted, mem_lee in the next cycle, second listo 3 cycles later.
